// File: rtl/awg_io_pkg.sv
// awg_io_pkg: shared I/O constants and status bit ordering for the AWG register map
package awg_io_pkg;
    localparam int   SYNC_STAGES_DEF = 2;
    localparam logic RST_LEVEL_DEF   = 1'b1;
    typedef enum logic [1:0] {
        st_rise    = 2'd0,
        st_fall    = 2'd1,
        st_chatter = 2'd2
    } status_bit_e;
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one-channel synchroniser, stable-count filter, edge pulses and sticky chatter flag
module debounce_ch
    import awg_io_pkg::*;
#(
    parameter int   P_CNT_W       = 16,
    parameter int   P_SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic P_RST_LEVEL   = RST_LEVEL_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               din,
    input  logic [P_CNT_W-1:0] len_eff,
    input  logic               chatter_clr,
    output logic               dout,
    output logic               rise,
    output logic               fall,
    output logic               chatter
);
    logic [P_SYNC_STAGES-1:0] sync;
    logic [P_CNT_W-1:0]       cnt;
    logic                     s, same, done, set;
    assign s    = sync[P_SYNC_STAGES-1];
    assign same = s == dout;
    assign done = {1'b0, cnt} + 1'b1 >= {1'b0, len_eff};
    assign set  = tick & same & (cnt != '0);
    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= {P_SYNC_STAGES{P_RST_LEVEL}};
            dout    <= P_RST_LEVEL;
            cnt     <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            chatter <= 1'b0;
        end else begin
            sync    <= {sync[P_SYNC_STAGES-2:0], din};
            rise    <= tick & ~same & done & s;
            fall    <= tick & ~same & done & ~s;
            chatter <= set | (chatter & ~chatter_clr);
            if (tick) begin
                cnt <= (same | done) ? '0 : cnt + 1'b1;
                if (!same && done) dout <= s;
            end
        end
    end
endmodule

// File: rtl/multi_ch_debounce.sv
// multi_ch_debounce: shared sample prescaler feeding P_CH independent debounce channels
module multi_ch_debounce
    import awg_io_pkg::*;
#(
    parameter int   P_CH          = 8,
    parameter int   P_CNT_W       = 16,
    parameter int   P_PRESC_W     = 8,
    parameter int   P_SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic P_RST_LEVEL   = RST_LEVEL_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [P_CH-1:0]      din,
    input  logic [P_CNT_W-1:0]   cfg_len,
    input  logic [P_PRESC_W-1:0] cfg_presc,
    input  logic [P_CH-1:0]      chatter_clr,
    output logic [P_CH-1:0]      dout,
    output logic [P_CH-1:0]      rise,
    output logic [P_CH-1:0]      fall,
    output logic [P_CH-1:0]      chatter
);
    logic [P_PRESC_W-1:0] presc_cnt;
    logic [P_CNT_W-1:0]   len_eff;
    logic                 tick;
    assign tick    = en & (presc_cnt >= cfg_presc);
    assign len_eff = (cfg_len == '0) ? P_CNT_W'(1) : cfg_len;
    always_ff @(posedge clk) begin
        presc_cnt <= (rst | ~en | tick) ? '0 : presc_cnt + 1'b1;
    end
    for (genvar g = 0; g < P_CH; g++) begin : g_ch
        debounce_ch #(
            .P_CNT_W      (P_CNT_W),
            .P_SYNC_STAGES(P_SYNC_STAGES),
            .P_RST_LEVEL  (P_RST_LEVEL)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .din        (din[g]),
            .len_eff    (len_eff),
            .chatter_clr(chatter_clr[g]),
            .dout       (dout[g]),
            .rise       (rise[g]),
            .fall       (fall[g]),
            .chatter    (chatter[g])
        );
    end
endmodule
